// File: rtl/md_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer_if
// Purpose  : Request/result bundle between the pipeline (master) and the
//            multiply/divide sequencer (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, src_a, src_b, cancel,
                  input  busy, done, hi, lo);
  modport slave  (input  start, op, src_a, src_b, cancel,
                  output busy, done, hi, lo);
endinterface
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : Iterative HI/LO multiply/divide unit. Radix-2 shift-add multiply
//            and restoring divide on magnitudes, 32 RUN cycles, sign fix-up in
//            FIX, commit to HI/LO on the FIX->IDLE edge.
//            Optional MADD/MSUB accumulate ops: define MD_SEQUENCER_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave bus
);
  localparam logic [2:0] OP_MULT    = 3'd1;
  localparam logic [2:0] OP_MULTU   = 3'd2;
  localparam logic [2:0] OP_DIV     = 3'd3;
  localparam logic [2:0] OP_DIVU    = 3'd4;
  localparam logic [2:0] OP_MADD    = 3'd5;
  localparam logic [2:0] OP_MSUB    = 3'd6;
  localparam logic [2:0] OP_MT      = 3'd7;
  localparam logic [4:0] LAST_COUNT = 5'd31;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;
  state_t state, state_next;

  logic [4:0]  count;
  logic [2:0]  op_reg;
  logic        neg_res;     // product/quotient must be negated in FIX
  logic        neg_rem;     // remainder must be negated in FIX
  logic [31:0] operand;     // multiplicand or divisor magnitude
  logic [31:0] shadow_hi;   // product high half / partial remainder
  logic [31:0] shadow_lo;   // product low half + multiplier / quotient
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic        done_reg;

  logic        is_mul, is_div, is_signed, accept, mt_write, commit;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] product, result;
  logic [31:0] quotient, remainder;

  // Decode the incoming request and take operand magnitudes
  always_comb begin
    is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
`ifdef MD_SEQUENCER_MADD_EN
    is_mul = is_mul || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
`endif
    // A zero divisor is simply not accepted, so HI/LO stay untouched
    is_div    = ((bus.op == OP_DIV) || (bus.op == OP_DIVU)) && (bus.src_b != 32'd0);
    is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV) ||
                (bus.op == OP_MADD) || (bus.op == OP_MSUB);
    accept    = bus.start && !bus.cancel && (state == IDLE) && (is_mul || is_div);
    mt_write  = bus.start && !bus.cancel && (state == IDLE) && (bus.op == OP_MT);
    abs_a     = (is_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    abs_b     = (is_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;
  end

  // Iteration step terms and sign-corrected results for commit
  always_comb begin
    mul_sum   = {1'b0, shadow_hi} + (shadow_lo[0] ? {1'b0, operand} : 33'd0);
    div_trial = {shadow_hi, shadow_lo[31]} - {1'b0, operand};
    product   = neg_res ? (64'd0 - {shadow_hi, shadow_lo}) : {shadow_hi, shadow_lo};
    quotient  = neg_res ? (32'd0 - shadow_lo) : shadow_lo;
    remainder = neg_rem ? (32'd0 - shadow_hi) : shadow_hi;
    result    = product;
    if ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) begin
      result = {remainder, quotient};
    end
`ifdef MD_SEQUENCER_MADD_EN
    if (op_reg == OP_MADD) begin
      result = {hi_reg, lo_reg} + product;
    end
    if (op_reg == OP_MSUB) begin
      result = {hi_reg, lo_reg} - product;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; commit only when FIX completes without a flush
  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.cancel) begin
          state_next = IDLE;
        end else if (count == LAST_COUNT) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
        commit     = !bus.cancel;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow datapath, iteration counter and architectural HI/LO
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= 5'd0;
      op_reg    <= 3'd0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      operand   <= 32'd0;
      shadow_hi <= 32'd0;
      shadow_lo <= 32'd0;
      hi_reg    <= 32'd0;
      lo_reg    <= 32'd0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        count     <= 5'd0;
        op_reg    <= bus.op;
        neg_res   <= is_signed && (bus.src_a[31] ^ bus.src_b[31]);
        neg_rem   <= is_signed && bus.src_a[31];
        operand   <= is_div ? abs_b : abs_a;
        shadow_hi <= 32'd0;
        shadow_lo <= is_div ? abs_a : abs_b;
      end else if ((state == RUN) && !bus.cancel) begin
        count <= count + 5'd1;
        if ((op_reg == OP_DIV) || (op_reg == OP_DIVU)) begin
          if (!div_trial[32]) begin
            shadow_hi <= div_trial[31:0];
            shadow_lo <= {shadow_lo[30:0], 1'b1};
          end else begin
            shadow_hi <= {shadow_hi[30:0], shadow_lo[31]};
            shadow_lo <= {shadow_lo[30:0], 1'b0};
          end
        end else begin
          // Accumulate into the upper half while the multiplier shifts out
          shadow_hi <= mul_sum[32:1];
          shadow_lo <= {mul_sum[0], shadow_lo[31:1]};
        end
      end
      if (mt_write) begin
        if (bus.src_b[0]) begin
          hi_reg <= bus.src_a;
        end else begin
          lo_reg <= bus.src_a;
        end
      end
      if (commit) begin
        {hi_reg, lo_reg} <= result;
        done_reg         <= 1'b1;
      end
    end
  end

  assign bus.busy = (state != IDLE) || accept;
  assign bus.done = done_reg;
  assign bus.hi   = hi_reg;
  assign bus.lo   = lo_reg;

endmodule
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Self-checking bench for md_sequencer with a behavioural HI/LO
//            model built on native signed/unsigned arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;
  logic        clk;
  logic        reset;
  int          vectors;
  int          miscompares;
  logic [31:0] mhi;
  logic [31:0] mlo;

  md_sequencer_if bus ();

  md_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  // Free-running clock
  always #5 clk = ~clk;

  // Expected {HI,LO} after one long op, given the current {HI,LO}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (o)
      3'd1: model = longint'(sa) * longint'(sb);
      3'd2: model = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else model = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4: model = {a % b, a / b};
      3'd5: model = cur + 64'(longint'(sa) * longint'(sb));
      3'd6: model = cur - 64'(longint'(sa) * longint'(sb));
      default: model = cur;
    endcase
  endfunction

  // Issue one op in the current cycle and follow it until busy drops (bounded).
  // poke>0 re-drives start with an unrelated DIVU in that cycle of the op.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke, output int bcycles, output logic dn);
    int n;
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b; bus.cancel = 1'b0;
    #1;
    bcycles = bus.busy ? 1 : 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (bus.busy && n < 100) begin
      if (n == poke) begin
        bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'd100; bus.src_b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      bcycles++;
      n++;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    #1;
    dn = bus.done;
  endtask

  task automatic mt_write(input logic sel_hi, input logic [31:0] data);
    bus.start = 1'b1; bus.op = 3'd7; bus.src_a = data; bus.src_b = {31'd0, sel_hi};
    bus.cancel = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    reset = 1'b1;
    @(posedge clk); #2;
    mhi = 32'd0; mlo = 32'd0;
  endtask

  task automatic test_mult();
    logic [31:0] a, b; logic [2:0] o; int bc; logic dn; logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin o = 3'd1; a = 32'hFFFF_FFFE; b = 32'd3; end
        1: begin o = 3'd1; a = 32'h8000_0000; b = 32'h8000_0000; end
        2: begin o = 3'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
        default: begin o = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2; a = $urandom; b = $urandom; end
      endcase
      exp = model(o, a, b, {mhi, mlo});
      do_op(o, a, b, -1, bc, dn);
      vectors++; if (bc !== 34) begin miscompares++; $display("FAIL mult_busy_len[%0d]: got %0d expected 34", i, bc); end
      vectors++; if (dn !== 1'b1) begin miscompares++; $display("FAIL mult_done[%0d]: got %b expected 1", i, dn); end
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL mult_hilo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, {bus.hi, bus.lo}, exp); end
      {mhi, mlo} = exp;
    end
    @(posedge clk); #2;
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_single_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_div();
    logic [31:0] a, b; logic [2:0] o; int bc; logic dn; logic [63:0] exp;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin o = 3'd3; a = 32'hFFFF_FFF9; b = 32'd2; end
        1: begin o = 3'd4; a = 32'd7; b = 32'd2; end
        2: begin o = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin
          o = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd4;
          a = $urandom;
          b = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 100));
          if (b == 32'd0) b = 32'd1;
          if (($urandom_range(0, 1) == 0) && o == 3'd3) b = 32'd0 - b;
        end
      endcase
      exp = model(o, a, b, {mhi, mlo});
      do_op(o, a, b, -1, bc, dn);
      vectors++; if (bc !== 34) begin miscompares++; $display("FAIL div_busy_len[%0d]: got %0d expected 34", i, bc); end
      vectors++; if (dn !== 1'b1) begin miscompares++; $display("FAIL div_done[%0d]: got %b expected 1", i, dn); end
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL div_hilo[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, a, b, {bus.hi, bus.lo}, exp); end
      {mhi, mlo} = exp;
    end
  endtask

  task automatic test_div_zero();
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.op = (i == 0) ? 3'd3 : 3'd4; bus.src_a = 32'd5; bus.src_b = 32'd0;
      #1;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL divzero_busy_now[%0d]: got %b expected 0", i, bus.busy); end
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL divzero_busy_later[%0d]: got %b expected 0", i, bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL divzero_done[%0d]: got %b expected 0", i, bus.done); end
      vectors++; if ({bus.hi, bus.lo} !== {mhi, mlo}) begin miscompares++; $display("FAIL divzero_hilo[%0d]: got %h expected %h", i, {bus.hi, bus.lo}, {mhi, mlo}); end
    end
  endtask

  task automatic test_cancel();
    int bc; logic dn; logic [63:0] exp; logic [31:0] a, b;
    // Flush while in RUN (cycle 10) and while in FIX (cycle 33)
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.op = 3'd2; bus.src_a = $urandom | 32'h1; bus.src_b = $urandom | 32'h1;
      bus.cancel = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat ((i == 0) ? 9 : 32) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      #1;
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL cancel_busy_before[%0d]: got %b expected 1", i, bus.busy); end
      @(posedge clk); #1;
      bus.cancel = 1'b0;
      #1;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL cancel_idle[%0d]: got %b expected 0", i, bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL cancel_done[%0d]: got %b expected 0", i, bus.done); end
      vectors++; if ({bus.hi, bus.lo} !== {mhi, mlo}) begin miscompares++; $display("FAIL cancel_hilo[%0d]: got %h expected %h", i, {bus.hi, bus.lo}, {mhi, mlo}); end
      // A fresh start is accepted in the cycle right after the flush
      a = $urandom; b = $urandom;
      exp = model(3'd1, a, b, {mhi, mlo});
      do_op(3'd1, a, b, -1, bc, dn);
      vectors++; if (bc !== 34) begin miscompares++; $display("FAIL cancel_restart_len[%0d]: got %0d expected 34", i, bc); end
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL cancel_restart_hilo[%0d]: got %h expected %h", i, {bus.hi, bus.lo}, exp); end
      {mhi, mlo} = exp;
    end
    // Start together with cancel is discarded
    bus.start = 1'b1; bus.op = 3'd1; bus.src_a = 32'd9; bus.src_b = 32'd9; bus.cancel = 1'b1;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL start_cancel_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL start_cancel_next: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = $urandom; bus.src_b = $urandom | 32'h1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    mhi = 32'd0; mlo = 32'd0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", bus.done); end
    vectors++; if ({bus.hi, bus.lo} !== 64'd0) begin miscompares++; $display("FAIL midreset_hilo: got %h expected 0", {bus.hi, bus.lo}); end
    // MTLO / MTHI write one cycle later, never busy or done
    bus.start = 1'b1; bus.op = 3'd7; bus.src_a = 32'h1234; bus.src_b = 32'd0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mtlo_busy: got %b expected 0", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b0;
    #1;
    mlo = 32'h1234;
    vectors++; if ({bus.hi, bus.lo} !== {mhi, mlo}) begin miscompares++; $display("FAIL mtlo_hilo: got %h expected %h", {bus.hi, bus.lo}, {mhi, mlo}); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mtlo_done: got %b expected 0", bus.done); end
    d = $urandom;
    mt_write(1'b1, d);
    mhi = d;
    vectors++; if ({bus.hi, bus.lo} !== {mhi, mlo}) begin miscompares++; $display("FAIL mthi_hilo: got %h expected %h", {bus.hi, bus.lo}, {mhi, mlo}); end
  endtask

  task automatic test_madd();
    mt_write(1'b1, 32'd0);
    mt_write(1'b0, 32'd5);
    mhi = 32'd0; mlo = 32'd5;
    vectors++; if ({bus.hi, bus.lo} !== 64'd5) begin miscompares++; $display("FAIL madd_preload: got %h expected 5", {bus.hi, bus.lo}); end
`ifdef MD_SEQUENCER_MADD_EN
    begin
      int bc; logic dn; logic [63:0] exp; logic [31:0] a, b; logic [2:0] o;
      for (int i = 0; i < 6; i++) begin
        if (i == 0) begin o = 3'd5; a = 32'd2; b = 32'd3; end
        else begin o = ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd6; a = $urandom; b = $urandom; end
        exp = model(o, a, b, {mhi, mlo});
        do_op(o, a, b, -1, bc, dn);
        vectors++; if (bc !== 34) begin miscompares++; $display("FAIL madd_busy_len[%0d]: got %0d expected 34", i, bc); end
        vectors++; if (dn !== 1'b1) begin miscompares++; $display("FAIL madd_done[%0d]: got %b expected 1", i, dn); end
        vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL madd_hilo[%0d] op=%0d: got %h expected %h", i, o, {bus.hi, bus.lo}, exp); end
        {mhi, mlo} = exp;
      end
    end
`else
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1; bus.op = (i == 0) ? 3'd5 : 3'd6; bus.src_a = 32'd2; bus.src_b = 32'd3;
      #1;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL madd_off_busy[%0d]: got %b expected 0", i, bus.busy); end
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL madd_off_busy_later[%0d]: got %b expected 0", i, bus.busy); end
      vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL madd_off_done[%0d]: got %b expected 0", i, bus.done); end
      vectors++; if ({bus.hi, bus.lo} !== 64'd5) begin miscompares++; $display("FAIL madd_off_hilo[%0d]: got %h expected 5", i, {bus.hi, bus.lo}); end
    end
`endif
  endtask

  task automatic test_back_to_back();
    int bc; logic dn; logic [63:0] exp; logic [31:0] a, b;
    // A start during RUN is ignored; the next op issues in the done cycle
    a = $urandom; b = $urandom;
    exp = model(3'd1, a, b, {mhi, mlo});
    do_op(3'd1, a, b, 5, bc, dn);
    vectors++; if (bc !== 34) begin miscompares++; $display("FAIL b2b_first_len: got %0d expected 34", bc); end
    vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL b2b_first_hilo: got %h expected %h", {bus.hi, bus.lo}, exp); end
    {mhi, mlo} = exp;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    exp = model(3'd4, a, b, {mhi, mlo});
    do_op(3'd4, a, b, -1, bc, dn);
    vectors++; if (bc !== 34) begin miscompares++; $display("FAIL b2b_second_len: got %0d expected 34", bc); end
    vectors++; if (dn !== 1'b1) begin miscompares++; $display("FAIL b2b_second_done: got %b expected 1", dn); end
    vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL b2b_second_hilo: got %h expected %h", {bus.hi, bus.lo}, exp); end
    {mhi, mlo} = exp;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Test sequence
  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_cancel();
    test_reset_mid();
    test_madd();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_sequencer.md
MD_SEQUENCER -- requirements
Module: md_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous active-low reset; 0 = reset.
REQ-004 start  in  1  request a new operation this cycle.
REQ-005 op  in  3  0=NOP, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MADD, 6=MSUB, 7=MTHI/MTLO (target chosen by src_b[0]: 1=HI, 0=LO).
REQ-006 src_a  in  32  operand A (multiplicand, dividend or MT data).
REQ-007 src_b  in  32  operand B (multiplier or divisor).
REQ-008 cancel  in  1  exception flush; aborts the in-flight operation.
REQ-009 busy  out  1  unit occupied; the pipeline stalls on it.
REQ-010 done  out  1  one-cycle pulse when HI/LO have just been committed.
REQ-011 hi  out  32  registered HI.
REQ-012 lo  out  32  registered LO.

Function
REQ-013 The state machine SHALL use states IDLE, RUN and FIX.
- Transitions: IDLE->RUN on accept; RUN->FIX when count=31; FIX->IDLE always.
REQ-014 A start SHALL be accepted only in IDLE with cancel=0 and a long op (1-6); start in RUN or FIX SHALL be ignored.
REQ-015 busy SHALL be (state!=IDLE) | (start & long op & state==IDLE & !cancel), i.e. asserted combinationally in the accept cycle.
REQ-016 The 5-bit iteration counter SHALL clear on accept and increment once per RUN cycle, giving exactly 32 RUN cycles.
REQ-017 Multiply SHALL use radix-2 shift-add on unsigned magnitudes into a 64-bit shadow product.
- Signed ops take the absolute values of both operands.
REQ-018 Divide SHALL use radix-2 restoring division on magnitudes.
- Quotient and remainder are held in shadow registers.
REQ-019 In FIX, signed results SHALL be sign-corrected.
- Product is negated if the signs differ.
- Quotient is negated if the signs differ; remainder takes the sign of the dividend.
- 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 On the FIX->IDLE edge, HI/LO SHALL be committed:
- MULT/MULTU: {HI,LO}=product.
- DIV/DIVU: HI=remainder, LO=quotient.
REQ-021 A start accepted in cycle 0 SHALL keep busy high in cycles 0..33; new HI/LO and done=1 appear in cycle 34.
REQ-022 DIV/DIVU with src_b=0 SHALL be ignored: no accept, busy=0, HI/LO unchanged.
REQ-023 MTHI/MTLO with start in IDLE and cancel=0 SHALL write HI or LO at the next edge, without busy or done.
REQ-024 cancel=1 in RUN or FIX SHALL return the FSM to IDLE at the next edge, with no commit and no done; HI/LO keep their pre-op values.
REQ-025 cancel and start in the same cycle SHALL discard the start.
REQ-026 Shadow registers SHALL never be visible on hi/lo before commit.

Reset
REQ-027 While reset=0 at a rising edge, all of the following SHALL clear: state=IDLE, counter=0, HI=0, LO=0, done=0, shadows=0.
REQ-028 Reset asserted mid-operation SHALL abort it.
- Outputs are busy=0, done=0, hi=0, lo=0 in the cycle after the reset edge.

Configuration
REQ-029 Macro MD_SEQUENCER_MADD_EN SHALL control the accumulate ops.
- Defined: MADD/MSUB use the signed multiply path, then commit {HI,LO}={HI,LO}+product or {HI,LO}-product (mod 2^64), with the same latency as MULT.
- Undefined: op 5/6 SHALL be treated as NOP, never accepted, and busy stays 0.

Verification
REQ-030 MULT with A=0xFFFFFFFE (-2), B=3 -> busy for 34 cycles; cycle 34 gives HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1.
REQ-031 DIV with A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with A=7, B=2 -> LO=3, HI=1.
REQ-032 DIV with A=5, B=0 -> busy stays 0, HI/LO unchanged, no done.
REQ-033 Start MULTU, then cancel=1 at cycle 10 -> IDLE at cycle 11, HI/LO unchanged; a second start is accepted at cycle 11.
REQ-034 reset=0 asserted at cycle 20 of a DIVU -> next cycle busy=0, hi=lo=0; MTLO with A=0x1234 afterwards -> lo=0x1234 one cycle later.
REQ-035 With MD_SEQUENCER_MADD_EN: HI/LO=0:5, then MADD 2*3 -> LO=11; without the macro, the same stimulus leaves LO=5 and busy=0.
